// File: rtl/r200_pkg.sv
// Shared types for the unified-memory arbiter: FSM states and port ids.
package r200_pkg;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_ACCESS,
    MA_DONE
  } ma_state_e;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/memarb_latcnt.sv
// Loadable down-counter timing one memory access; saturates at zero.
module memarb_latcnt #(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int W = $clog2(MEM_LAT) + 1;
  localparam logic [W-1:0] LOAD_VAL = W'(MEM_LAT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = LOAD_VAL;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_arbiter.sv
// IF/LS arbiter for the single-port unified memory, fixed-latency access.
// Define MEMARB_RR_EN for round-robin; default is LS-over-IF priority.
module mem_arbiter
  import r200_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MEM_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_ack,
  output logic [XLEN-1:0] ls_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  ma_state_e       state_q, state_d;
  logic            grant_q, grant_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic            if_ack_q, if_ack_d;
  logic            ls_ack_q, ls_ack_d;
  logic            cnt_load, cnt_dec, cnt_zero;
  logic            pick_ls;

`ifdef MEMARB_RR_EN
  logic last_q, last_d;

  // On contention, favour the port that did not win last time.
  assign pick_ls = ls_req && (!if_req || (last_q == PORT_IF));

  always_comb begin
    last_d = last_q;
    if ((state_q == MA_IDLE) && (if_req || ls_req)) begin
      last_d = pick_ls ? PORT_LS : PORT_IF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_IF;
    end else begin
      last_q <= last_d;
    end
  end
`else
  assign pick_ls = ls_req;
`endif

  memarb_latcnt #(
    .MEM_LAT(MEM_LAT)
  ) u_latcnt (
    .clk (clk),
    .rst (rst),
    .load(cnt_load),
    .dec (cnt_dec),
    .zero(cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    ls_rdata_d = ls_rdata_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    unique case (state_q)
      MA_IDLE: begin
        if (if_req || ls_req) begin
          grant_d  = pick_ls ? PORT_LS : PORT_IF;
          addr_d   = pick_ls ? ls_addr : if_addr;
          we_d     = pick_ls && ls_we;
          wdata_d  = pick_ls ? ls_wdata : '0;
          cnt_load = 1'b1;
          state_d  = MA_ACCESS;
        end
      end
      MA_ACCESS: begin
        if (cnt_zero) begin
          if (grant_q == PORT_LS) begin
            ls_rdata_d = mem_rdata;
          end else begin
            if_rdata_d = mem_rdata;
          end
          state_d = MA_DONE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      MA_DONE: begin
        state_d = MA_IDLE;
      end
      default: begin
        state_d = MA_IDLE;
      end
    endcase
    // Outputs come from flops loaded with the next-state decode.
    mem_en_d = (state_d == MA_ACCESS);
    mem_we_d = mem_en_d && we_d;
    if_ack_d = (state_d == MA_DONE) && (grant_d == PORT_IF);
    ls_ack_d = (state_d == MA_DONE) && (grant_d == PORT_LS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MA_IDLE;
      grant_q    <= PORT_IF;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      ls_rdata_q <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      ls_ack_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      ls_rdata_q <= ls_rdata_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      if_ack_q   <= if_ack_d;
      ls_ack_q   <= ls_ack_d;
    end
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with MEM_LAT=2 (fixed priority or MEMARB_RR_EN).
module tb_mem_arbiter;

  localparam int XLEN = 32;
  localparam int LAT  = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic            if_ack;
  logic [XLEN-1:0] if_rdata;
  logic            ls_req;
  logic            ls_we;
  logic [XLEN-1:0] ls_addr;
  logic [XLEN-1:0] ls_wdata;
  logic            ls_ack;
  logic [XLEN-1:0] ls_rdata;
  logic            mem_en;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(
    .XLEN   (XLEN),
    .MEM_LAT(LAT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_ack   (if_ack),
    .if_rdata (if_rdata),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_ack   (ls_ack),
    .ls_rdata (ls_rdata),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n;
  logic [15:0] order;
  logic [15:0] exp_order;

  initial begin
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = '0;
    ls_req    = 1'b0;
    ls_we     = 1'b0;
    ls_addr   = '0;
    ls_wdata  = '0;
    mem_rdata = '0;
    tick();
    tick();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", if_rdata | ls_rdata | mem_wdata, 32'd0);
    rst = 1'b0;
    tick();

    // single fetch
    if_req    = 1'b1;
    if_addr   = 32'h100;
    mem_rdata = 32'hDEADBEEF;
    tick();
    chk("f_en1", {31'd0, mem_en}, 32'd1);
    chk("f_addr1", mem_addr, 32'h100);
    chk("f_we1", {31'd0, mem_we}, 32'd0);
    tick();
    chk("f_en2", {31'd0, mem_en}, 32'd1);
    chk("f_ack_early", {31'd0, if_ack}, 32'd0);
    tick();
    chk("f_en3", {31'd0, mem_en}, 32'd0);
    chk("f_ack", {31'd0, if_ack}, 32'd1);
    chk("f_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    tick();
    chk("f_ack_once", {31'd0, if_ack}, 32'd0);

    // store, with ls_addr disturbed mid-access
    ls_req    = 1'b1;
    ls_we     = 1'b1;
    ls_addr   = 32'h2000;
    ls_wdata  = 32'h12345678;
    mem_rdata = 32'h0BADF00D;
    tick();
    chk("s_we1", {30'd0, mem_en, mem_we}, 32'd3);
    chk("s_addr1", mem_addr, 32'h2000);
    chk("s_wdata1", mem_wdata, 32'h12345678);
    ls_addr  = 32'h3000;
    ls_wdata = 32'hFFFF0000;
    tick();
    chk("s_we2", {30'd0, mem_en, mem_we}, 32'd3);
    chk("s_addr_latched", mem_addr, 32'h2000);
    chk("s_wdata2", mem_wdata, 32'h12345678);
    tick();
    chk("s_ls_ack", {31'd0, ls_ack}, 32'd1);
    chk("s_if_ack", {31'd0, if_ack}, 32'd0);
    chk("s_we_off", {30'd0, mem_en, mem_we}, 32'd0);
    chk("s_ls_rdata", ls_rdata, 32'h0BADF00D);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    tick();
    chk("s_ack_once", {31'd0, ls_ack}, 32'd0);

    // reset so both builds start from last grant = IF
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // simultaneous requests: LS first, IF 4 cycles after ls_ack
    if_req  = 1'b1;
    if_addr = 32'h140;
    ls_req  = 1'b1;
    ls_addr = 32'h4000;
    tick();
    chk("b_ls_addr", mem_addr, 32'h4000);
    tick();
    tick();
    chk("b_acks_ls", {30'd0, if_ack, ls_ack}, 32'd1);
    ls_req = 1'b0;
    n = 0;
    while (!if_ack && n < 20) begin
      tick();
      n++;
    end
    chk("b_if_delay", n, 32'd4);
    chk("b_if_rdata", if_rdata, mem_rdata);
    if_req = 1'b0;
    tick();

    // both held: 8 acks in 32 cycles
    if_req    = 1'b1;
    ls_req    = 1'b1;
    order     = '0;
    exp_order = '0;
`ifdef MEMARB_RR_EN
    exp_order = 16'b1001100110011001;
`else
    exp_order = 16'b0101010101010101;
`endif
    n = 0;
    for (int c = 0; c < 32; c++) begin
      tick();
      if (if_ack || ls_ack) begin
        if (n < 8) begin
          order[2*n +: 2] = {if_ack, ls_ack};
        end
        n++;
      end
    end
    chk("h_ack_count", n, 32'd8);
    chk("h_order", {16'd0, order}, {16'd0, exp_order});
    if_req = 1'b0;
    ls_req = 1'b0;
    tick();
    tick();
    tick();
    tick();

    // reset in the second ACCESS cycle of a store
    ls_req   = 1'b1;
    ls_we    = 1'b1;
    ls_addr  = 32'h5000;
    ls_wdata = 32'hA5A5A5A5;
    tick();
    tick();
    chk("r_en_pre", {30'd0, mem_en, mem_we}, 32'd3);
    rst = 1'b1;
    #1;
    chk("r_en_async", {30'd0, mem_en, mem_we}, 32'd0);
    chk("r_acks", {30'd0, if_ack, ls_ack}, 32'd0);
    tick();
    chk("r_no_ack", {30'd0, if_ack, ls_ack}, 32'd0);
    rst = 1'b0;
    n = 0;
    while (!ls_ack && n < 20) begin
      tick();
      n++;
    end
    chk("r_restart", n, LAT + 1);
    ls_req = 1'b0;
    ls_we  = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
